// File: rtl/checkers_pkg.sv
// Shared types and constants for the checkers board datapath.
// Piece codes are {king, white, black}.
package checkers_pkg;

  localparam int NUM_SQ = 32;
  localparam int SQ_W   = 5;

  localparam logic [2:0] CODE_EMPTY = 3'b000;
  localparam logic [2:0] CODE_BMAN  = 3'b001;
  localparam logic [2:0] CODE_WMAN  = 3'b010;
  localparam logic [2:0] CODE_BKING = 3'b101;
  localparam logic [2:0] CODE_WKING = 3'b110;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  function automatic logic code_illegal(
    input logic [2:0] c
  );
    return (c != CODE_EMPTY) &&
           (c != CODE_BMAN)  &&
           (c != CODE_WMAN)  &&
           (c != CODE_BKING) &&
           (c != CODE_WKING);
  endfunction

endpackage

// File: rtl/board_untransform.sv
// Inverse board-layout transform for one bitboard.
// Low nibble of every byte is bit-reversed; high nibble passes through.
module board_untransform (
  input  logic [31:0] stored,
  output logic [31:0] logical
);

  always_comb begin
    logical = '0;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 4; k++) begin
        logical[8*b+k]   = stored[8*b+3-k];
        logical[8*b+4+k] = stored[8*b+4+k];
      end
    end
  end

endmodule

// File: rtl/board_decoder.sv
// Restores logical square order of a board snapshot and streams
// one square per beat with piece code, error flag and frame error count.
module board_decoder
  import checkers_pkg::*;
#(
  parameter int NUM_SQ = 32,
  parameter bit FLIP   = 1'b0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_black,
  input  logic [31:0]     in_white,
  input  logic [31:0]     in_kings,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SQ_W-1:0] out_square,
  output logic [2:0]      out_code,
  output logic            out_err,
  output logic            out_last,
  output logic            frame_done,
  output logic [5:0]      err_count
);

  localparam logic [SQ_W-1:0] SQ_LO = '0;
  localparam logic [SQ_W-1:0] SQ_HI = SQ_W'(NUM_SQ - 1);
  localparam logic [SQ_W-1:0] FIRST = FLIP ? SQ_HI : SQ_LO;
  localparam logic [SQ_W-1:0] LAST  = FLIP ? SQ_LO : SQ_HI;

  state_t          state, state_nx;
  logic [31:0]     b_d, w_d, k_d;
  logic [31:0]     b_q, w_q, k_q;
  logic [SQ_W-1:0] idx, idx_nx;
  logic [5:0]      run, run_nx;
  logic [5:0]      errc_nx;
  logic            done_nx;
  logic            ld;
  logic [2:0]      code;
  logic            illegal;

  board_untransform u_black (.stored(in_black), .logical(b_d));
  board_untransform u_white (.stored(in_white), .logical(w_d));
  board_untransform u_kings (.stored(in_kings), .logical(k_d));

  assign code    = {k_q[idx], w_q[idx], b_q[idx]};
  assign illegal = code_illegal(code);

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    run_nx     = run;
    errc_nx    = err_count;
    done_nx    = 1'b0;
    ld         = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_square = '0;
    out_code   = '0;
    out_err    = 1'b0;
    out_last   = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = ~reset;
        if (in_valid) begin
          ld       = 1'b1;
          idx_nx   = FIRST;
          run_nx   = '0;
          state_nx = STREAM;
        end
      end
      STREAM: begin
        out_valid  = 1'b1;
        out_square = idx;
        out_code   = code;
        out_err    = illegal;
        out_last   = (idx == LAST);
        if (out_ready) begin
          run_nx = run + 6'(illegal);
          if (idx == LAST) begin
            state_nx = IDLE;
            errc_nx  = run_nx;
            done_nx  = 1'b1;
          end else begin
            idx_nx = FLIP ? idx - 1'b1 : idx + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      run        <= '0;
      err_count  <= '0;
      frame_done <= 1'b0;
      b_q        <= '0;
      w_q        <= '0;
      k_q        <= '0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      run        <= run_nx;
      err_count  <= errc_nx;
      frame_done <= done_nx;
      if (ld) begin
        b_q <= b_d;
        w_q <= w_d;
        k_q <= k_d;
      end
    end
  end

endmodule

// File: tb/tb_board_decoder.sv
// Directed table-driven bench for board_decoder (FLIP=0 and FLIP=1).
module tb_board_decoder;

  typedef struct {
    logic [31:0] b;
    logic [31:0] w;
    logic [31:0] k;
    int          sq0;
    logic [2:0]  c0;
    int          sq1;
    logic [2:0]  c1;
    int          errs;
    int          stall_at;
    int          stall_len;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_black, in_white, in_kings;
  logic [4:0]  out_square;
  logic [2:0]  out_code;
  logic        out_err, out_last, frame_done;
  logic [5:0]  err_count;

  logic        f_in_valid, f_in_ready, f_out_valid, f_out_ready;
  logic [31:0] f_in_black, f_in_white, f_in_kings;
  logic [4:0]  f_out_square;
  logic [2:0]  f_out_code;
  logic        f_out_err, f_out_last, f_frame_done;
  logic [5:0]  f_err_count;

  board_decoder #(.NUM_SQ(32), .FLIP(1'b0)) dut (
    .clock(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_black(in_black), .in_white(in_white), .in_kings(in_kings),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_square(out_square), .out_code(out_code),
    .out_err(out_err), .out_last(out_last),
    .frame_done(frame_done), .err_count(err_count)
  );

  board_decoder #(.NUM_SQ(32), .FLIP(1'b1)) dut_flip (
    .clock(clk), .reset(reset),
    .in_valid(f_in_valid), .in_ready(f_in_ready),
    .in_black(f_in_black), .in_white(f_in_white), .in_kings(f_in_kings),
    .out_valid(f_out_valid), .out_ready(f_out_ready),
    .out_square(f_out_square), .out_code(f_out_code),
    .out_err(f_out_err), .out_last(f_out_last),
    .frame_done(f_frame_done), .err_count(f_err_count)
  );

  int checks = 0;
  int errors = 0;
  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] exp_code(input vec_t v, input int n);
    if (n == v.sq0) return v.c0;
    if (n == v.sq1) return v.c1;
    return 3'b000;
  endfunction

  function automatic logic exp_err(input logic [2:0] c);
    return (c == 3'b011) || (c == 3'b100) || (c == 3'b111);
  endfunction

  task automatic run_frame(input vec_t v, input int prev);
    logic [4:0] hs;
    logic [2:0] hc, e;
    chk("idle_in_ready", in_ready, 1);
    in_valid  = 1'b1;
    in_black  = v.b;
    in_white  = v.w;
    in_kings  = v.k;
    out_ready = 1'b1;
    @(negedge clk);
    in_black = 32'hA5A5_5A5A;
    in_white = 32'h5A5A_A5A5;
    in_kings = 32'hFFFF_0000;
    chk("err_count_hold", err_count, prev);
    for (int n = 0; n < 32; n++) begin
      e = exp_code(v, n);
      chk("beat_valid", out_valid, 1);
      chk("beat_square", out_square, n);
      chk("beat_code", out_code, e);
      chk("beat_err", out_err, exp_err(e));
      chk("beat_last", out_last, n == 31);
      chk("busy_in_ready", in_ready, 0);
      if (n == 31) in_valid = 1'b0;
      if (n == v.stall_at) begin
        out_ready = 1'b0;
        hs = out_square;
        hc = out_code;
        repeat (v.stall_len) begin
          @(negedge clk);
          chk("bp_valid", out_valid, 1);
          chk("bp_square", out_square, hs);
          chk("bp_code", out_code, hc);
          chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    chk("frame_done", frame_done, 1);
    chk("end_valid", out_valid, 0);
    chk("end_in_ready", in_ready, 1);
    chk("err_count", err_count, v.errs);
    @(negedge clk);
    chk("done_pulse", frame_done, 0);
  endtask

  initial begin
    vt[0] = '{32'h0000_0001, 32'h0, 32'h0, 3, 3'b001, -1, 3'b000, 0, -1, 0};
    vt[1] = '{32'h0, 32'h0000_0010, 32'h0000_0010,
              4, 3'b110, -1, 3'b000, 0, -1, 0};
    vt[2] = '{32'h8000_0000, 32'h8000_0000, 32'h0100_0000,
              31, 3'b011, 27, 3'b100, 2, -1, 0};
    vt[3] = '{32'h0000_0100, 32'h0, 32'h0000_0100,
              11, 3'b101, -1, 3'b000, 0, -1, 0};
    vt[4] = '{32'h0040_0000, 32'h0000_0002, 32'h0,
              2, 3'b010, 22, 3'b001, 0, -1, 0};
    vt[5] = '{32'h0000_0001, 32'h0, 32'h0, 3, 3'b001, -1, 3'b000, 0, 7, 5};
    vt[6] = vt[2];

    reset = 1'b1;
    in_valid = 1'b0; in_black = '0; in_white = '0; in_kings = '0;
    out_ready = 1'b1;
    f_in_valid = 1'b0; f_in_black = '0; f_in_white = '0; f_in_kings = '0;
    f_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_square", out_square, 0);
    chk("rst_out_code", out_code, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_f_in_ready", f_in_ready, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_frame(vt[i], (i == 0) ? 0 : vt[i-1].errs);

    // Reset part-way through a frame whose error total would be nonzero.
    in_valid  = 1'b1;
    in_black  = vt[2].b;
    in_white  = vt[2].w;
    in_kings  = vt[2].k;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_square", out_square, 10);
    chk("pre_rst_err_count", err_count, 2);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_frame_done", frame_done, 0);
    reset = 1'b0;
    #1;
    chk("after_rst_in_ready", in_ready, 1);
    chk("after_rst_err_count", err_count, 0);
    @(negedge clk);
    chk("after_rst_no_done", frame_done, 0);
    chk("after_rst_out_valid", out_valid, 0);
    run_frame(vt[0], 0);

    // Opponent view: all black men, streamed 31 down to 0.
    chk("flip_in_ready", f_in_ready, 1);
    f_in_valid = 1'b1;
    f_in_black = 32'hFFFF_FFFF;
    @(negedge clk);
    f_in_valid = 1'b0;
    f_in_black = '0;
    for (int n = 0; n < 32; n++) begin
      chk("flip_valid", f_out_valid, 1);
      chk("flip_square", f_out_square, 31 - n);
      chk("flip_code", f_out_code, 3'b001);
      chk("flip_err", f_out_err, 0);
      chk("flip_last", f_out_last, n == 31);
      @(negedge clk);
    end
    chk("flip_frame_done", f_frame_done, 1);
    chk("flip_err_count", f_err_count, 0);
    chk("flip_end_valid", f_out_valid, 0);
    @(negedge clk);
    chk("flip_done_pulse", f_frame_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_decoder.md
Name: board_decoder

Overview:
Reverse path of the board-layout transform. Accepts one board snapshot as three 32-bit bitboards (black, white, kings) in stored (transformed) layout and restores logical square order. It then streams the 32 squares one per beat, each with a piece code, to consumers such as the VGA square renderer and the move-validation debug port. Each square is checked for illegal encodings, and a per-frame error count is reported.

Parameters:
NUM_SQ, 32, squares per board; fixed at 32 and used for counter width and terminal count only.
FLIP, 0, when 1 stream squares 31 down to 0 (opponent's view); when 0 stream 0 up to 31.

Ports:
clock  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  board snapshot present.
in_ready  out  1  block can accept a snapshot.
in_black  in  32  black-occupancy bitboard, stored layout.
in_white  in  32  white-occupancy bitboard, stored layout.
in_kings  in  32  king bitboard, stored layout.
out_valid  out  1  square beat valid.
out_ready  in  1  consumer accepts beat.
out_square  out  5  logical square index of current beat.
out_code  out  3  piece code {king, white, black} for that square.
out_err  out  1  current square encoding illegal.
out_last  out  1  final beat of frame.
frame_done  out  1  one-cycle pulse after last beat accepted.
err_count  out  6  illegal squares in most recent completed frame (0..32).

Behaviour:
- Reset values: in_ready=0 during the reset cycle, then 1. out_valid=0, out_square=0, out_code=0, out_err=0, out_last=0, frame_done=0, err_count=0.
- Inverse mapping, applied identically to each bitboard, for byte b=0..3 and k=0..3:
  - logical[8b+k] = stored[8b+3-k] (low nibble of each byte bit-reversed).
  - logical[8b+4+k] = stored[8b+4+k] (high nibble passes through).
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid, latch the three decoded bitboards, set idx to 0 (FLIP=0) or 31 (FLIP=1), clear the running error counter, and go to STREAM. Beat 0 is valid on the next cycle, so accept-to-first-beat latency is 1.
  - STREAM: in_ready=0, out_valid=1.
    - out_square=idx.
    - out_code={K[idx],W[idx],B[idx]} from the latched registers.
    - out_err=1 when B&W, or when K without B or W.
    - out_last=1 when idx is the terminal index (31 if FLIP=0, 0 if FLIP=1).
    - On out_valid&out_ready: add out_err to the running count, then step idx by +1 (FLIP=0) or -1 (FLIP=1).
    - Last beat accepted: go to IDLE, pulse frame_done next cycle, load err_count with the final total.
- Backpressure: while out_valid&~out_ready, all out_* signals hold stable and idx does not move. There is no timeout.
- Throughput: one beat per cycle while out_ready=1. A frame is 32 beats plus 1 IDLE cycle, so a new snapshot can be accepted in the same cycle as the frame_done pulse.
- Inputs ignored: in_valid is ignored outside IDLE, and snapshot inputs are sampled only on the accept edge.
- err_count holds its value until the next frame completes. It is not cleared on accept.
- idx never wraps: termination is by state change, not counter overflow.
- Reset mid-stream: the partial frame is discarded with no frame_done pulse. err_count is reset to 0 and the block returns to IDLE.
- Code table:
  - 000 empty; 001 black man; 010 white man; 101 black king; 110 white king.
  - 011 and 111 are colour conflicts; 100 is an orphan king. All three are errors.

Decomposition:
- Shared package checkers_pkg:
  - NUM_SQ, SQ_W=5.
  - Piece-code constants: CODE_EMPTY, CODE_BMAN, CODE_WMAN, CODE_BKING, CODE_WKING.
  - FSM state encoding: IDLE, STREAM.
- Sub-module board_untransform: 32-in/32-out combinational inverse mapping, instantiated three times (black, white, kings).

Test Plan:
- Single-bit mapping: black=32'h0000_0001, others 0, FLIP=0, out_ready=1 -> exactly one nonzero beat, square 3 with code 001; out_last on square 31; frame_done one cycle later; err_count=0.
- High-nibble pass-through: white=32'h0000_0010, kings=32'h0000_0010 -> square 4 code 110, all others 000, no errors.
- Illegal encodings: black=white=32'h8000_0000, kings=32'h0100_0000 -> square 31 code 011 with out_err=1; square 27 code 100 with out_err=1; err_count=2.
- Backpressure: drop out_ready for 5 cycles at square 7 -> square 7 and out_code held unchanged; in_ready stays 0; frame still has 32 beats and completes.
- FLIP=1 with black=32'hFFFF_FFFF -> beat order 31..0; out_last on square 0; all codes 001.
- Reset at beat 10, then a new snapshot -> out_valid=0 and in_ready=1 after reset; no frame_done; err_count=0; next frame starts at square 0.
